// File: rtl/ad9958_pkg.sv
// Shared definitions for the AD9958 serial-port receiver: register map,
// per-register data lengths, reset defaults and the frame FSM encoding.
package ad9958_pkg;

   localparam logic [4:0] ADDR_CSR   = 5'h00;
   localparam logic [4:0] ADDR_FR1   = 5'h01;
   localparam logic [4:0] ADDR_FR2   = 5'h02;
   localparam logic [4:0] ADDR_CFR   = 5'h03;
   localparam logic [4:0] ADDR_CFTW0 = 5'h04;
   localparam logic [4:0] ADDR_CPOW0 = 5'h05;
   localparam logic [4:0] ADDR_ACR   = 5'h06;

   localparam logic [7:0] CSR_DEFAULT        = 8'hF0;
   localparam logic [1:0] DAC_FSCALE_DEFAULT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_INSTR,
      ST_DATA,
      ST_SKIP
   } state_t;

   // Data bytes following the instruction byte; zero marks an illegal address.
   function automatic logic [2:0] dataLength(input logic [4:0] addr);
      logic [2:0] len;
      case (addr)
         ADDR_CSR:   len = 3'd1;
         ADDR_FR1:   len = 3'd3;
         ADDR_FR2:   len = 3'd2;
         ADDR_CFR:   len = 3'd3;
         ADDR_CFTW0: len = 3'd4;
         ADDR_CPOW0: len = 3'd2;
         ADDR_ACR:   len = 3'd3;
         default:    len = 3'd0;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/ad9958_spi_sampler.sv
// Synchronizes the asynchronous serial-port pins into the system clock domain
// and turns them into single-cycle nibble, cs-edge and io_update strobes.
module ad9958_spi_sampler
   import ad9958_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       cs_i,
   input  logic       sclk_i,
   input  logic [3:0] sdio_i,
   input  logic       ioUpdate_i,
   input  logic       masterReset_i,
   output logic       nibbleValid_o,
   output logic [3:0] nibble_o,
   output logic       csRise_o,
   output logic       csFall_o,
   output logic       ioUpdateRise_o,
   output logic       masterReset_o
);

   // Bit order {master_reset, io_update, sdio[3:0], sclk, cs}; cs idles high.
   localparam logic [7:0] SYNC_RESET = 8'h01;

   logic [7:0] sync_q [SYNC_STAGES];
   logic [7:0] synced;
   logic       sclkPrev_q;
   logic       csPrev_q;
   logic       ioUpdatePrev_q;

   assign synced = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= SYNC_RESET;
         end
         sclkPrev_q     <= 1'b0;
         csPrev_q       <= 1'b1;
         ioUpdatePrev_q <= 1'b0;
      end else begin
         sync_q[0] <= {masterReset_i, ioUpdate_i, sdio_i, sclk_i, cs_i};
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         sclkPrev_q     <= synced[1];
         csPrev_q       <= synced[0];
         ioUpdatePrev_q <= synced[6];
      end
   end

   assign nibbleValid_o  = synced[1] & ~sclkPrev_q & ~synced[0];
   assign nibble_o       = synced[5:2];
   assign csRise_o       = synced[0] & ~csPrev_q;
   assign csFall_o       = ~synced[0] & csPrev_q;
   assign ioUpdateRise_o = synced[6] & ~ioUpdatePrev_q;
   assign masterReset_o  = synced[7];

endmodule

// File: rtl/ad9958_spi_slave.sv
// AD9958 stand-in: decodes quad-SDIO write frames into a shadow register file
// and commits the shadows to the active outputs on each io_update rising edge.
module ad9958_spi_slave
   import ad9958_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cs,
   input  logic        sclk,
   input  logic [3:0]  sdio,
   input  logic        io_update,
   input  logic        master_reset,
   output logic [31:0] ftw_ch0,
   output logic [31:0] ftw_ch1,
   output logic [9:0]  asf_ch0,
   output logic [9:0]  asf_ch1,
   output logic        vco_gain,
   output logic [4:0]  clock_multiplier,
   output logic [1:0]  dac_fscale_ch0,
   output logic [1:0]  dac_fscale_ch1,
   output logic        write_strobe,
   output logic [4:0]  write_addr,
   output logic        frame_error
);

   logic       nibbleValid, csRise, csFall, ioUpdateRise, masterReset;
   logic [3:0] nibble;

   ad9958_spi_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
      .clock         (clock),
      .reset         (reset),
      .cs_i          (cs),
      .sclk_i        (sclk),
      .sdio_i        (sdio),
      .ioUpdate_i    (io_update),
      .masterReset_i (master_reset),
      .nibbleValid_o (nibbleValid),
      .nibble_o      (nibble),
      .csRise_o      (csRise),
      .csFall_o      (csFall),
      .ioUpdateRise_o(ioUpdateRise),
      .masterReset_o (masterReset)
   );

   state_t      state_q, state_d;
   logic [2:0]  nibbleCnt_q, nibbleCnt_d;
   logic [27:0] shift_q, shift_d;
   logic [4:0]  addr_q, addr_d;
   logic [1:0]  chEn_q, chEn_d;
   logic        writeEn, errorPulse;
   logic [31:0] writeData;
   logic [4:0]  instrAddr;
   logic [3:0]  lastNibble;

   assign instrAddr  = {shift_q[0], nibble};
   assign lastNibble = {dataLength(addr_q), 1'b0} - 4'd1;
   assign writeData  = {shift_q, nibble};

   always_ff @(posedge clock) begin
      if (reset || masterReset) begin
         state_q     <= ST_IDLE;
         nibbleCnt_q <= '0;
         shift_q     <= '0;
         addr_q      <= '0;
         chEn_q      <= '0;
      end else begin
         state_q     <= state_d;
         nibbleCnt_q <= nibbleCnt_d;
         shift_q     <= shift_d;
         addr_q      <= addr_d;
         chEn_q      <= chEn_d;
      end
   end

   // Only the CSR channel-enable bits carry behaviour, so only they are stored.
   logic [1:0]  csrEn_q;

   always_comb begin
      state_d     = state_q;
      nibbleCnt_d = nibbleCnt_q;
      shift_d     = shift_q;
      addr_d      = addr_q;
      chEn_d      = chEn_q;
      writeEn     = 1'b0;
      errorPulse  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (csFall) begin
               state_d     = ST_INSTR;
               nibbleCnt_d = '0;
            end
         end
         ST_INSTR: begin
            if (csRise) begin
               state_d    = ST_IDLE;
               errorPulse = (nibbleCnt_q != 3'd0);
            end else if (nibbleValid) begin
               if (nibbleCnt_q == 3'd0) begin
                  shift_d     = {shift_q[23:0], nibble};
                  nibbleCnt_d = 3'd1;
               end else begin
                  nibbleCnt_d = '0;
                  addr_d      = instrAddr;
                  if (shift_q[3] || (dataLength(instrAddr) == 3'd0)) begin
                     state_d    = ST_SKIP;
                     errorPulse = 1'b1;
                  end else begin
                     state_d = ST_DATA;
                     chEn_d  = csrEn_q;
                  end
               end
            end
         end
         ST_DATA: begin
            if (csRise) begin
               state_d    = ST_IDLE;
               errorPulse = 1'b1;
            end else if (nibbleValid) begin
               shift_d = {shift_q[23:0], nibble};
               if ({1'b0, nibbleCnt_q} == lastNibble) begin
                  writeEn     = 1'b1;
                  state_d     = ST_INSTR;
                  nibbleCnt_d = '0;
               end else begin
                  nibbleCnt_d = nibbleCnt_q + 3'd1;
               end
            end
         end
         ST_SKIP: begin
            if (csRise) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   logic [31:0] ftwSh0_q, ftwSh1_q, ftw0_q, ftw1_q;
   logic [9:0]  asfSh0_q, asfSh1_q, asf0_q, asf1_q;
   logic [1:0]  dacSh0_q, dacSh1_q, dac0_q, dac1_q;
   logic        vcoSh_q, vco_q, strobe_q, error_q;
   logic [4:0]  multSh_q, mult_q, writeAddr_q;

   // Shadows load on write completion; actives sample the pre-write shadows.
   always_ff @(posedge clock) begin
      if (reset || masterReset) begin
         csrEn_q  <= CSR_DEFAULT[7:6];
         ftwSh0_q <= '0;  ftwSh1_q <= '0;  ftw0_q <= '0;  ftw1_q <= '0;
         asfSh0_q <= '0;  asfSh1_q <= '0;  asf0_q <= '0;  asf1_q <= '0;
         dacSh0_q <= DAC_FSCALE_DEFAULT;  dacSh1_q <= DAC_FSCALE_DEFAULT;
         dac0_q   <= DAC_FSCALE_DEFAULT;  dac1_q   <= DAC_FSCALE_DEFAULT;
         vcoSh_q  <= 1'b0;  vco_q  <= 1'b0;
         multSh_q <= '0;    mult_q <= '0;
         strobe_q <= 1'b0;  error_q <= 1'b0;  writeAddr_q <= '0;
      end else begin
         strobe_q <= writeEn;
         error_q  <= errorPulse;
         if (writeEn) begin
            writeAddr_q <= addr_q;
            case (addr_q)
               ADDR_CSR: csrEn_q <= writeData[7:6];
               ADDR_FR1: begin
                  vcoSh_q  <= writeData[23];
                  multSh_q <= writeData[22:18];
               end
               ADDR_CFR: begin
                  if (chEn_q[0]) dacSh0_q <= writeData[9:8];
                  if (chEn_q[1]) dacSh1_q <= writeData[9:8];
               end
               ADDR_CFTW0: begin
                  if (chEn_q[0]) ftwSh0_q <= writeData;
                  if (chEn_q[1]) ftwSh1_q <= writeData;
               end
               ADDR_ACR: begin
                  if (chEn_q[0]) asfSh0_q <= writeData[9:0];
                  if (chEn_q[1]) asfSh1_q <= writeData[9:0];
               end
               default: ;
            endcase
         end
         if (ioUpdateRise) begin
            ftw0_q <= ftwSh0_q;  ftw1_q <= ftwSh1_q;
            asf0_q <= asfSh0_q;  asf1_q <= asfSh1_q;
            dac0_q <= dacSh0_q;  dac1_q <= dacSh1_q;
            vco_q  <= vcoSh_q;   mult_q <= multSh_q;
         end
      end
   end

   assign ftw_ch0          = ftw0_q;
   assign ftw_ch1          = ftw1_q;
   assign asf_ch0          = asf0_q;
   assign asf_ch1          = asf1_q;
   assign vco_gain         = vco_q;
   assign clock_multiplier = mult_q;
   assign dac_fscale_ch0   = dac0_q;
   assign dac_fscale_ch1   = dac1_q;
   assign write_strobe     = strobe_q;
   assign write_addr       = writeAddr_q;
   assign frame_error      = error_q;

endmodule

// File: tb/tb_ad9958_spi_slave.sv
// Bench for ad9958_spi_slave: table of CSR+register frames with expected active
// outputs, a write-address scoreboard, and hand sequences for error/reset cases.
module tb_ad9958_spi_slave;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cs = 1'b1;
   logic        sclk = 1'b0;
   logic [3:0]  sdio = 4'h0;
   logic        io_update = 1'b0;
   logic        master_reset = 1'b0;
   logic [31:0] ftw_ch0, ftw_ch1;
   logic [9:0]  asf_ch0, asf_ch1;
   logic        vco_gain;
   logic [4:0]  clock_multiplier;
   logic [1:0]  dac_fscale_ch0, dac_fscale_ch1;
   logic        write_strobe;
   logic [4:0]  write_addr;
   logic        frame_error;

   ad9958_spi_slave #(.SYNC_STAGES(2)) dut (
      .clock           (clock),
      .reset           (reset),
      .cs              (cs),
      .sclk            (sclk),
      .sdio            (sdio),
      .io_update       (io_update),
      .master_reset    (master_reset),
      .ftw_ch0         (ftw_ch0),
      .ftw_ch1         (ftw_ch1),
      .asf_ch0         (asf_ch0),
      .asf_ch1         (asf_ch1),
      .vco_gain        (vco_gain),
      .clock_multiplier(clock_multiplier),
      .dac_fscale_ch0  (dac_fscale_ch0),
      .dac_fscale_ch1  (dac_fscale_ch1),
      .write_strobe    (write_strobe),
      .write_addr      (write_addr),
      .frame_error     (frame_error)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0]  csr;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [2:0]  nbytes;
      logic [31:0] ftw0, ftw1;
      logic [9:0]  asf0, asf1;
      logic        vco;
      logic [4:0]  mult;
      logic [1:0]  dac0, dac1;
   } vec_t;

   vec_t       vecs [8];
   logic [4:0] expAddrQ [$];
   int         vectorCount = 0;
   int         missCount = 0;
   int         strobeCount = 0;
   int         errorCount = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Scoreboard: every write_strobe must match the oldest queued write address.
   always @(negedge clock) begin
      if (!reset) begin
         if (write_strobe === 1'b1) begin
            strobeCount++;
            if (expAddrQ.size() == 0) begin
               checkOutput("unexpected_strobe", {27'd0, write_addr}, 32'hFFFF_FFFF);
            end else begin
               checkOutput("write_addr", {27'd0, write_addr}, {27'd0, expAddrQ.pop_front()});
            end
         end
         if (frame_error === 1'b1) errorCount++;
      end
   end

   task automatic sendNibble(input logic [3:0] n);
      @(negedge clock) sdio = n;
      repeat (3) @(negedge clock);
      sclk = 1'b1;
      repeat (3) @(negedge clock);
      sclk = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] b);
      sendNibble(b[7:4]);
      sendNibble(b[3:0]);
   endtask

   task automatic csLow();
      @(negedge clock) cs = 1'b0;
      repeat (3) @(negedge clock);
   endtask

   task automatic csHigh();
      repeat (3) @(negedge clock);
      cs = 1'b1;
      repeat (8) @(negedge clock);
   endtask

   task automatic writeReg(input logic [4:0] addr, input logic [31:0] data,
                           input logic [2:0] nbytes);
      expAddrQ.push_back(addr);
      sendByte({3'b000, addr});
      for (int b = int'(nbytes) - 1; b >= 0; b--) begin
         sendByte(data[8*b +: 8]);
      end
   endtask

   task automatic pulseIoUpdate();
      @(negedge clock) io_update = 1'b1;
      repeat (4) @(negedge clock);
      io_update = 1'b0;
      repeat (6) @(negedge clock);
   endtask

   task automatic checkAll(input string tag, input logic [31:0] f0, input logic [31:0] f1,
                           input logic [9:0] a0, input logic [9:0] a1, input logic v,
                           input logic [4:0] m, input logic [1:0] d0, input logic [1:0] d1);
      checkOutput({tag, ".ftw_ch0"}, ftw_ch0, f0);
      checkOutput({tag, ".ftw_ch1"}, ftw_ch1, f1);
      checkOutput({tag, ".asf_ch0"}, {22'd0, asf_ch0}, {22'd0, a0});
      checkOutput({tag, ".asf_ch1"}, {22'd0, asf_ch1}, {22'd0, a1});
      checkOutput({tag, ".vco_gain"}, {31'd0, vco_gain}, {31'd0, v});
      checkOutput({tag, ".clock_multiplier"}, {27'd0, clock_multiplier}, {27'd0, m});
      checkOutput({tag, ".dac_fscale_ch0"}, {30'd0, dac_fscale_ch0}, {30'd0, d0});
      checkOutput({tag, ".dac_fscale_ch1"}, {30'd0, dac_fscale_ch1}, {30'd0, d1});
   endtask

   task automatic applyStimulus(input int idx);
      int s0;
      s0 = strobeCount;
      csLow();
      writeReg(5'h00, {24'd0, vecs[idx].csr}, 3'd1);
      writeReg(vecs[idx].addr, vecs[idx].data, vecs[idx].nbytes);
      csHigh();
      pulseIoUpdate();
      checkOutput($sformatf("vec%0d.strobes", idx), strobeCount - s0, 2);
      checkAll($sformatf("vec%0d", idx), vecs[idx].ftw0, vecs[idx].ftw1, vecs[idx].asf0,
               vecs[idx].asf1, vecs[idx].vco, vecs[idx].mult, vecs[idx].dac0, vecs[idx].dac1);
   endtask

   initial begin
      int s0, e0;
      // Expected values accumulate: each row is the full active state after its frame.
      vecs[0] = '{8'h40, 5'h04, 32'h1234_5678, 3'd4, 32'h1234_5678, 32'h0, 10'h000, 10'h000, 1'b0, 5'h00, 2'b11, 2'b11};
      vecs[1] = '{8'hC0, 5'h06, 32'h0000_03FF, 3'd3, 32'h1234_5678, 32'h0, 10'h3FF, 10'h3FF, 1'b0, 5'h00, 2'b11, 2'b11};
      vecs[2] = '{8'h80, 5'h04, 32'hDEAD_BEEF, 3'd4, 32'h1234_5678, 32'hDEAD_BEEF, 10'h3FF, 10'h3FF, 1'b0, 5'h00, 2'b11, 2'b11};
      vecs[3] = '{8'h40, 5'h03, 32'h0000_0200, 3'd3, 32'h1234_5678, 32'hDEAD_BEEF, 10'h3FF, 10'h3FF, 1'b0, 5'h00, 2'b10, 2'b11};
      vecs[4] = '{8'h80, 5'h06, 32'h0000_0155, 3'd3, 32'h1234_5678, 32'hDEAD_BEEF, 10'h3FF, 10'h155, 1'b0, 5'h00, 2'b10, 2'b11};
      vecs[5] = '{8'hC0, 5'h01, 32'h007C_0000, 3'd3, 32'h1234_5678, 32'hDEAD_BEEF, 10'h3FF, 10'h155, 1'b0, 5'h1F, 2'b10, 2'b11};
      vecs[6] = '{8'h00, 5'h04, 32'hFFFF_FFFF, 3'd4, 32'h1234_5678, 32'hDEAD_BEEF, 10'h3FF, 10'h155, 1'b0, 5'h1F, 2'b10, 2'b11};
      vecs[7] = '{8'hC0, 5'h05, 32'h0000_ABCD, 3'd2, 32'h1234_5678, 32'hDEAD_BEEF, 10'h3FF, 10'h155, 1'b0, 5'h1F, 2'b10, 2'b11};

      repeat (5) @(negedge clock);
      reset = 1'b0;
      repeat (4) @(negedge clock);
      checkAll("reset", 32'h0, 32'h0, 10'h0, 10'h0, 1'b0, 5'h0, 2'b11, 2'b11);
      checkOutput("reset.write_strobe", {31'd0, write_strobe}, 32'd0);
      checkOutput("reset.write_addr", {27'd0, write_addr}, 32'd0);
      checkOutput("reset.frame_error", {31'd0, frame_error}, 32'd0);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(i);
      end

      // FR1 and CFR in one frame stay in the shadows until io_update.
      csLow();
      writeReg(5'h01, 32'h00D0_0000, 3'd3);
      writeReg(5'h03, 32'h0000_0100, 3'd3);
      csHigh();
      checkAll("pre_update", 32'h1234_5678, 32'hDEAD_BEEF, 10'h3FF, 10'h155, 1'b0, 5'h1F, 2'b10, 2'b11);
      checkOutput("pre_update.write_addr", {27'd0, write_addr}, 32'h3);
      pulseIoUpdate();
      checkAll("post_update", 32'h1234_5678, 32'hDEAD_BEEF, 10'h3FF, 10'h155, 1'b1, 5'h14, 2'b01, 2'b01);

      // Read instruction: error, and the CSR-looking bytes after it are ignored.
      s0 = strobeCount; e0 = errorCount;
      csLow();
      sendByte(8'h84);
      sendByte(8'h00);
      sendByte(8'h40);
      csHigh();
      checkOutput("read.errors", errorCount - e0, 1);
      checkOutput("read.strobes", strobeCount - s0, 0);

      s0 = strobeCount; e0 = errorCount;
      csLow();
      sendByte(8'h07);
      csHigh();
      checkOutput("illegal.errors", errorCount - e0, 1);
      checkOutput("illegal.strobes", strobeCount - s0, 0);

      // CFTW0 aborted after 5 of 8 data nibbles must not reach the shadow.
      s0 = strobeCount; e0 = errorCount;
      csLow();
      sendByte(8'h04);
      for (int n = 0; n < 5; n++) sendNibble(4'hA);
      csHigh();
      checkOutput("abort.errors", errorCount - e0, 1);
      checkOutput("abort.strobes", strobeCount - s0, 0);
      pulseIoUpdate();
      checkOutput("abort.ftw_ch0", ftw_ch0, 32'h1234_5678);
      checkOutput("abort.ftw_ch1", ftw_ch1, 32'hDEAD_BEEF);

      e0 = errorCount;
      csLow();
      sendNibble(4'h0);
      csHigh();
      checkOutput("half_instr.errors", errorCount - e0, 1);

      @(negedge clock) master_reset = 1'b1;
      repeat (4) @(negedge clock);
      master_reset = 1'b0;
      repeat (6) @(negedge clock);
      checkAll("mreset", 32'h0, 32'h0, 10'h0, 10'h0, 1'b0, 5'h0, 2'b11, 2'b11);
      checkOutput("mreset.write_addr", {27'd0, write_addr}, 32'd0);

      // CSR is back to 0xF0, so an un-prefixed CFTW0 reaches both channels.
      csLow();
      writeReg(5'h04, 32'h0BAD_F00D, 3'd4);
      csHigh();
      pulseIoUpdate();
      checkOutput("csr_default.ftw_ch0", ftw_ch0, 32'h0BAD_F00D);
      checkOutput("csr_default.ftw_ch1", ftw_ch1, 32'h0BAD_F00D);

      repeat (4) @(negedge clock);
      checkOutput("pending_writes", expAddrQ.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
